// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices, FSM states and core modes for alu_flag_unit (ALU_MUL_EN adds the MUL state)
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_EOR  = 4'd6;
    localparam logic [3:0] OP_INC  = 4'd7;
    localparam logic [3:0] OP_DEC  = 4'd8;
    localparam logic [3:0] OP_ADIW = 4'd9;
    localparam logic [3:0] OP_SBIW = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC    = 3'd1,
        ST_WORD_HI = 3'd2,
`ifdef ALU_MUL_EN
        ST_MUL_2   = 3'd4,
`endif
        ST_DONE    = 3'd3
    } state_t;

    typedef enum logic [2:0] {
        CORE_ADD = 3'd0,
        CORE_SUB = 3'd1,
        CORE_AND = 3'd2,
        CORE_OR  = 3'd3,
        CORE_EOR = 3'd4
    } core_mode_t;

endpackage

// File: rtl/alu_flag_unit_if.sv
// rtl/alu_flag_unit_if.sv - launch/result bus between the sequencer and alu_flag_unit
interface alu_flag_unit_if #(
    parameter int DW  = 8,
    parameter int OPW = 4
);
    logic           start;
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  a_hi;
    logic [DW-1:0]  b;
    logic           c_in;
    logic           busy;
    logic           done;
    logic [DW-1:0]  result;
    logic [DW-1:0]  result_hi;
    logic [2:0]     flags;
    logic           sr_we;

    modport master (
        output start, op, a, a_hi, b, c_in,
        input  busy, done, result, result_hi, flags, sr_we
    );

    modport slave (
        input  start, op, a, a_hi, b, c_in,
        output busy, done, result, result_hi, flags, sr_we
    );
endinterface

// File: rtl/alu_byte_core.sv
// rtl/alu_byte_core.sv - combinational byte add/sub/logic slice with carry/borrow in and out
module alu_byte_core
    import alu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin,
    input  core_mode_t    mode,
    output logic [DW-1:0] y,
    output logic          cout
);

    logic [DW:0] sum;

    // One extra bit holds carry (add) or borrow (sub, two's-complement sign)
    always_comb begin
        sum = '0;
        case (mode)
            CORE_ADD: sum = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
            CORE_SUB: sum = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, cin};
            CORE_AND: sum = {1'b0, a & b};
            CORE_OR:  sum = {1'b0, a | b};
            CORE_EOR: sum = {1'b0, a ^ b};
            default:  sum = '0;
        endcase
        y    = sum[DW-1:0];
        cout = sum[DW];
    end

endmodule

// File: rtl/alu_flag_unit.sv
// rtl/alu_flag_unit.sv - sequenced byte/word ALU feeding the status register; ALU_MUL_EN enables op 11 multiply
module alu_flag_unit
    import alu_pkg::*;
#(
    parameter int DW  = 8,
    parameter int OPW = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_flag_unit_if.slave    bus
);

    state_t          state, state_nxt;
    logic [OPW-1:0]  op_q;
    logic [DW-1:0]   a_q, a_hi_q, b_q, lo_q;
    logic            c_q, carry_q;
    logic [DW-1:0]   core_a, core_b, core_y;
    logic            core_cin, core_cout;
    core_mode_t      core_mode;
    logic [DW-1:0]   result_q, result_hi_q, res_nxt, res_hi_nxt;
    logic [2:0]      flags_q, flags_nxt;
    logic            load, busy, done;
    logic            is_word;

    assign is_word = (op_q == OP_ADIW) || (op_q == OP_SBIW);

`ifdef ALU_MUL_EN
    logic [2*DW-1:0] prod_q, mul_lo, mul_hi, product;

    // Multiply split into a low-nibble pass (EXEC) and a high-nibble pass (MUL_2)
    assign mul_lo  = {{DW{1'b0}}, a_q} * {{(DW + DW/2){1'b0}}, b_q[DW/2-1:0]};
    assign mul_hi  = {{DW{1'b0}}, a_q} * {{(DW + DW/2){1'b0}}, b_q[DW-1:DW/2]};
    assign product = prod_q + (mul_hi << (DW/2));

    // Partial product register between the two multiply passes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  prod_q <= '0;
        else if (state == ST_EXEC) prod_q <= mul_lo;
    end
`endif

    // State register; reset aborts any in-flight op without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: start is only honoured in IDLE, so starts during busy or DONE are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.start) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (is_word)                state_nxt = ST_WORD_HI;
`ifdef ALU_MUL_EN
                else if (op_q == OP_MUL)    state_nxt = ST_MUL_2;
`endif
                else                        state_nxt = ST_DONE;
            end
            ST_WORD_HI: state_nxt = ST_DONE;
`ifdef ALU_MUL_EN
            ST_MUL_2:   state_nxt = ST_DONE;
`endif
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs decoded straight from the state register
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Latch operands at launch; keep low byte and carry for the word high-byte pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            a_hi_q  <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            lo_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.start) begin
                op_q   <= bus.op;
                a_q    <= bus.a;
                a_hi_q <= bus.a_hi;
                b_q    <= bus.b;
                c_q    <= bus.c_in;
            end
            if (state == ST_EXEC) begin
                lo_q    <= core_y;
                carry_q <= core_cout;
            end
        end
    end

    // Core operand steering: WORD_HI propagates the low-byte carry/borrow into a_hi
    always_comb begin
        core_a    = a_q;
        core_b    = b_q;
        core_cin  = 1'b0;
        core_mode = CORE_ADD;
        if (state == ST_WORD_HI) begin
            core_a    = a_hi_q;
            core_b    = '0;
            core_cin  = carry_q;
            core_mode = (op_q == OP_SBIW) ? CORE_SUB : CORE_ADD;
        end else begin
            case (op_q)
                OP_ADC:  core_cin = c_q;
                OP_SUB:  core_mode = CORE_SUB;
                OP_SBC: begin core_mode = CORE_SUB; core_cin = c_q; end
                OP_AND:  core_mode = CORE_AND;
                OP_OR:   core_mode = CORE_OR;
                OP_EOR:  core_mode = CORE_EOR;
                OP_INC:  core_b = {{(DW-1){1'b0}}, 1'b1};
                OP_DEC: begin core_mode = CORE_SUB; core_b = {{(DW-1){1'b0}}, 1'b1}; end
                OP_ADIW: core_b = {{(DW-6){1'b0}}, b_q[5:0]};
                OP_SBIW: begin core_mode = CORE_SUB; core_b = {{(DW-6){1'b0}}, b_q[5:0]}; end
                default: ;
            endcase
        end
    end

    alu_byte_core #(.DW(DW)) u_core (
        .a    (core_a),
        .b    (core_b),
        .cin  (core_cin),
        .mode (core_mode),
        .y    (core_y),
        .cout (core_cout)
    );

    // Final result/flags, loaded on the transition into DONE
    always_comb begin
        load       = 1'b0;
        res_nxt    = result_q;
        res_hi_nxt = result_hi_q;
        flags_nxt  = flags_q;
        if (state_nxt == ST_DONE) begin
            load = 1'b1;
            case (state)
                ST_EXEC: begin
                    res_hi_nxt = '0;
                    case (op_q)
                        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_EOR, OP_INC, OP_DEC: begin
                            res_nxt          = core_y;
                            flags_nxt[FLG_N] = core_y[DW-1];
                            flags_nxt[FLG_Z] = (core_y == '0);
                            flags_nxt[FLG_C] = core_cout;
                            if (op_q == OP_AND || op_q == OP_OR || op_q == OP_EOR)
                                flags_nxt[FLG_C] = 1'b0;
                            if (op_q == OP_INC || op_q == OP_DEC)
                                flags_nxt[FLG_C] = c_q;
                        end
                        default: res_nxt = a_q;
                    endcase
                end
                ST_WORD_HI: begin
                    res_nxt          = lo_q;
                    res_hi_nxt       = core_y;
                    flags_nxt[FLG_N] = core_y[DW-1];
                    flags_nxt[FLG_Z] = ({core_y, lo_q} == '0);
                    flags_nxt[FLG_C] = core_cout;
                end
`ifdef ALU_MUL_EN
                ST_MUL_2: begin
                    {res_hi_nxt, res_nxt} = product;
                    flags_nxt[FLG_N]      = product[2*DW-1];
                    flags_nxt[FLG_Z]      = (product == '0);
                    flags_nxt[FLG_C]      = product[2*DW-1];
                end
`endif
                default: load = 1'b0;
            endcase
        end
    end

    // Result and flag registers hold between completions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= 3'b000;
        end else if (load) begin
            result_q    <= res_nxt;
            result_hi_q <= res_hi_nxt;
            flags_q     <= flags_nxt;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.sr_we     = done;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb/tb_alu_flag_unit.sv - self-checking bench for alu_flag_unit with an arithmetic reference model
module tb_alu_flag_unit;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [2:0] exp_flags = 3'b000;

    alu_flag_unit_if #(.DW(8), .OPW(4)) bus ();

    alu_flag_unit #(.DW(8), .OPW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input int op, input int a, input int ah, input int b, input int cin,
                             input logic [2:0] pf, output int rh, output int r,
                             output logic [2:0] f, output int lat);
        int s;
        int w;
        int imm;
        rh  = 0;
        r   = a;
        f   = pf;
        lat = 2;
        imm = b % 64;
        case (op)
            0, 1: begin
                s = a + b + ((op == 1) ? cin : 0);
                r = s % 256;
                f = {r >= 128, r == 0, s > 255};
            end
            2, 3: begin
                s = b + ((op == 3) ? cin : 0);
                r = (a - s + 512) % 256;
                f = {r >= 128, r == 0, a < s};
            end
            4: begin r = a & b; f = {r >= 128, r == 0, 1'b0}; end
            5: begin r = a | b; f = {r >= 128, r == 0, 1'b0}; end
            6: begin r = a ^ b; f = {r >= 128, r == 0, 1'b0}; end
            7: begin r = (a + 1) % 256;   f = {r >= 128, r == 0, cin != 0}; end
            8: begin r = (a + 255) % 256; f = {r >= 128, r == 0, cin != 0}; end
            9, 10: begin
                w = ah * 256 + a;
                if (op == 9) begin s = w + imm; f[0] = (s > 65535); end
                else         begin s = w - imm; f[0] = (s < 0);     end
                s = (s + 65536) % 65536;
                rh = s / 256;
                r  = s % 256;
                f[2] = (rh >= 128);
                f[1] = (s == 0);
                lat = 3;
            end
`ifdef ALU_MUL_EN
            11: begin
                s  = a * b;
                rh = s / 256;
                r  = s % 256;
                f  = {s >= 32768, s == 0, s >= 32768};
                lat = 3;
            end
`endif
            default: begin r = a; f = pf; end
        endcase
    endtask

    task automatic scramble();
        bus.start = 1'($urandom_range(0, 1));
        bus.op    = 4'($urandom_range(0, 15));
        bus.a     = 8'($urandom_range(0, 255));
        bus.a_hi  = 8'($urandom_range(0, 255));
        bus.b     = 8'($urandom_range(0, 255));
        bus.c_in  = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input string tag, input int op_v, input int a_v, input int ah_v,
                          input int b_v, input int cin_v);
        int erh;
        int er;
        int lat;
        int n;
        logic [2:0] ef;
        ref_model(op_v, a_v, ah_v, b_v, cin_v, exp_flags, erh, er, ef, lat);
        bus.start = 1'b1;
        bus.op    = 4'(op_v);
        bus.a     = 8'(a_v);
        bus.a_hi  = 8'(ah_v);
        bus.b     = 8'(b_v);
        bus.c_in  = 1'(cin_v);
        @(negedge clk);
        n = 1;
        check({tag, ":busy"}, 32'(bus.busy), 32'd1);
        while (bus.done !== 1'b1 && n < 8) begin
            scramble();
            @(negedge clk);
            n++;
        end
        check({tag, ":latency"}, 32'(n), 32'(lat));
        check({tag, ":result"}, 32'(bus.result), 32'(er));
        check({tag, ":result_hi"}, 32'(bus.result_hi), 32'(erh));
        check({tag, ":flags"}, 32'(bus.flags), 32'(ef));
        check({tag, ":sr_we"}, 32'(bus.sr_we), 32'd1);
        exp_flags = ef;
        scramble();
        bus.start = 1'b1;
        @(negedge clk);
        check({tag, ":done_1cyc"}, {30'd0, bus.done, bus.sr_we}, 32'd0);
        check({tag, ":start_in_done_ignored"}, 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.a_hi  = '0;
        bus.b     = '0;
        bus.c_in  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset:busy_done_srwe", {29'd0, bus.busy, bus.done, bus.sr_we}, 32'd0);
        check("reset:result", {16'd0, bus.result_hi, bus.result}, 32'd0);
        check("reset:flags", 32'(bus.flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_ff_01", 0, 8'hFF, 0, 8'h01, 0);
        run_op("sub_00_01", 2, 8'h00, 0, 8'h01, 0);
        run_op("sbc_05_04", 3, 8'h05, 0, 8'h04, 1);
        run_op("adc_7f_00", 1, 8'h7F, 0, 8'h00, 1);
        run_op("inc_ff", 7, 8'hFF, 0, 0, 1);
        run_op("dec_00", 8, 8'h00, 0, 0, 0);
        run_op("and_zero", 4, 8'hF0, 0, 8'h0F, 1);
        run_op("adiw_00ff_1", 9, 8'hFF, 8'h00, 8'h01, 0);
        run_op("adiw_ffff_3f", 9, 8'hFF, 8'hFF, 8'hFF, 0);
        run_op("sbiw_0000_1", 10, 8'h00, 8'h00, 8'h01, 0);
        run_op("op11_ff_ff", 11, 8'hFF, 0, 8'hFF, 0);
        run_op("nop_15", 15, 8'h5A, 0, 8'h11, 1);

        for (int i = 0; i < 40; i++) begin
            run_op("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 1)));
        end

        bus.start = 1'b1;
        bus.op    = 4'd9;
        bus.a     = 8'hFF;
        bus.a_hi  = 8'h12;
        bus.b     = 8'h01;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_mid:busy_in_word_hi", {30'd0, bus.busy, bus.done}, 32'd2);
        rst = 1'b1;
        #1;
        check("rst_mid:outputs_cleared",
              {5'd0, bus.busy, bus.done, bus.sr_we, bus.flags, bus.result_hi, bus.result}, 32'd0);
        @(negedge clk);
        check("rst_mid:no_done", {30'd0, bus.done, bus.sr_we}, 32'd0);
        rst = 1'b0;
        exp_flags = 3'b000;
        @(negedge clk);
        check("rst_mid:still_idle", {29'd0, bus.busy, bus.done, bus.sr_we}, 32'd0);
        run_op("after_rst_add", 0, 8'h03, 0, 8'h04, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
